ysyx_220066_lsu: RTL and testbench
==================================

# ysyx_220066_lsu

Load/store unit forming the MEM stage directly downstream of the EX-stage ALU. It takes the ALU-computed effective address and store data, then runs a valid/ready transaction on the data-memory port. It aligns store data and byte masks and extracts and extends load data. Non-memory results pass through with one cycle of latency, and the unit stalls EX until each memory access completes.

## Interface
Parameters: none (XLEN fixed at 64).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  EX result valid.
- in_ready  out  1  LSU can accept; equals 1 only in IDLE and not in reset.
- in_ren  in  1  load.
- in_wen  in  1  store.
- in_funct3  in  3  [1:0] size: 0=B, 1=H, 2=W, 3=D. [2]=1 selects an unsigned load.
- in_addr  in  64  effective address, also the ALU result for non-memory ops.
- in_wdata  in  64  rs2 store data.
- in_rd  in  5  destination tag, passed through.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  64  equals {in_addr[63:3], 3'b0}.
- mem_wen  out  1  1 for a store request.
- mem_wdata  out  64  lane-aligned store data.
- mem_wmask  out  8  byte strobes; 0 for a load.
- mem_resp_valid  in  1  load data or store ack.
- mem_rdata  in  64  load data.
- out_valid  out  1  result to WB, one-cycle pulse.
- out_data  out  64  result.
- out_rd  out  5  tag.
- out_misalign  out  1  misaligned-access flag.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Accept:
  - A request is accepted when in_valid & in_ready are both 1 in IDLE.
  - On accept, latch addr, funct3, wdata, rd and the op type.
- Op decode:
  - in_ren=1 gives a load, even if in_wen=1 (decode never emits both).
  - in_wen=1 alone gives a store.
  - Neither set gives a pass-through op.
- Misalignment:
  - The access is misaligned when any of these holds:
    - size H and addr[0] != 0;
    - size W and addr[1:0] != 0;
    - size D and addr[2:0] != 0.
  - A misaligned load or store issues no memory request and goes IDLE -> DONE.
  - It returns out_data = address and out_misalign = 1.
- Pass-through op: IDLE -> DONE, out_data = in_addr.
- Aligned memory op:
  - IDLE -> REQ.
  - REQ holds mem_req_valid=1 with stable addr/wen/wdata/wmask until mem_req_ready=1, then goes to WAIT.
  - WAIT goes to DONE on mem_resp_valid=1.
  - mem_resp_valid is ignored outside WAIT.
- DONE: out_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- Store lane rules, with o = addr[2:0]:
  - mem_wdata = wdata << (8*o).
  - mem_wmask is 8'h01<<o for B, 8'h03<<o for H, 8'h0F<<o for W, 8'hFF for D.
- Load extraction:
  - s = mem_rdata >> (8*o), captured on the response.
  - Take s[7:0], s[15:0], s[31:0] or s[63:0] according to size.
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
  - funct3=3'b111 is treated as an LD.
- Store result: out_data = 0.
- Registered outputs: out_data, out_rd and out_misalign are registers, held stable from DONE until the next DONE.

## Timing
- Reset state:
  - FSM = IDLE.
  - in_ready=0 during reset and 1 in the first cycle after reset.
  - mem_req_valid=0, mem_wen=0, mem_wmask=0.
  - mem_addr=0, mem_wdata=0.
  - out_valid=0, out_data=0, out_rd=0, out_misalign=0.
- Pass-through or misaligned op: accepted in cycle t, out_valid in cycle t+1, in_ready again in cycle t+2.
- Memory op, minimum case:
  - Accept in cycle t.
  - mem_req_valid from cycle t+1; handshake in t+1 when ready is already high.
  - Response at the earliest in t+2.
  - out_valid in t+3.
  - Each extra cycle of ready or response delay adds one cycle.
- A response arriving in the same cycle as the request handshake is not sampled. The memory must respond no earlier than one cycle after the handshake.
- mem_req_valid, once raised, stays high until it is accepted and never drops while mem_req_ready=0. The only exception is reset.
- Reset mid-transaction:
  - The transaction is abandoned and mem_req_valid=0 in the next cycle.
  - A stale mem_resp_valid arriving afterwards in IDLE is ignored and produces no out_valid.
- in_valid while busy: no accept. Upstream holds its inputs until in_ready=1.

## Test plan
- Pass-through: in_addr=64'h1234, rd=5, no ren/wen -> out_valid one cycle later, out_data=64'h1234, out_rd=5, no mem_req_valid.
- LB sign extension: addr=64'h8000_0003, funct3=0; mem_rdata=64'h0000_0000_8000_0000 -> mem_addr=64'h8000_0000, mem_wmask=0, out_data=64'hFFFF_FFFF_FFFF_FF80. The same access with funct3=4 -> out_data=64'h80.
- SH lanes: addr=64'h8000_0006, wdata=64'hABCD -> mem_wdata=64'hABCD_0000_0000_0000, mem_wmask=8'hC0, mem_wen=1, out_data=0 after the ack.
- Backpressure: hold mem_req_ready=0 for 4 cycles on an SD to addr=64'h8000_0008 -> mem_req_valid and all request fields stable for those 4 cycles, in_ready=0, then mem_wmask=8'hFF.
- Misaligned: LW at addr=64'h8000_0002 -> no request, out_misalign=1, out_data=64'h8000_0002 at t+1.
- Reset in WAIT: assert rst for one cycle, then pulse mem_resp_valid in IDLE -> out_valid stays 0, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_220066_lsu_if.sv
// Signal bundle between the EX stage, the data-memory port and WB for the MEM-stage LSU.
// The master modport is the LSU side; slave is the surrounding pipeline/memory side.
interface ysyx_220066_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_ren;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;

    modport master (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output out_valid, out_data, out_rd, out_misalign
    );

    modport slave (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, in_rd,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  out_valid, out_data, out_rd, out_misalign
    );
endinterface

// File: rtl/ysyx_220066_lsu.sv
// MEM-stage load/store unit: one valid/ready memory transaction per accepted EX result,
// with store lane alignment, load extraction/extension and one-cycle non-memory pass-through.
module ysyx_220066_lsu (
    input  logic              clk,
    input  logic              rst,
    ysyx_220066_lsu_if.master lsu_bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
    typedef enum logic [1:0] {OpPass, OpLoad, OpStore} op_e;

    state_e      r_state;
    state_e      w_state_next;
    op_e         r_op;
    op_e         w_op;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [63:0] r_out_data;
    logic [4:0]  r_out_rd;
    logic        r_out_misalign;
    logic        w_accept;
    logic        w_misalign;
    logic        w_resp;
    logic        w_sext;
    logic [7:0]  w_wmask;
    logic [63:0] w_rdata_sh;
    logic [63:0] w_load_data;

    always_comb begin
        if (lsu_bus.in_ren) begin
            w_op = OpLoad;
        end else if (lsu_bus.in_wen) begin
            w_op = OpStore;
        end else begin
            w_op = OpPass;
        end
    end

    always_comb begin
        w_misalign = 1'b0;
        case (lsu_bus.in_funct3[1:0])
            2'd1:    w_misalign = lsu_bus.in_addr[0];
            2'd2:    w_misalign = |lsu_bus.in_addr[1:0];
            2'd3:    w_misalign = |lsu_bus.in_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
        if (w_op == OpPass) begin
            w_misalign = 1'b0;
        end
    end

    assign w_accept = lsu_bus.in_valid & lsu_bus.in_ready;
    // A response is only meaningful once the request handshake has completed.
    assign w_resp   = (r_state == StWait) & lsu_bus.mem_resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = (w_op == OpPass || w_misalign) ? StDone : StReq;
                end
            end
            StReq:   if (lsu_bus.mem_req_ready) w_state_next = StWait;
            StWait:  if (lsu_bus.mem_resp_valid) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        lsu_bus.in_ready      = (r_state == StIdle) & ~rst;
        lsu_bus.mem_req_valid = (r_state == StReq);
        lsu_bus.out_valid     = (r_state == StDone);
    end

    always_comb begin
        w_wmask = 8'hFF;
        case (r_funct3[1:0])
            2'd0:    w_wmask = 8'h01 << r_addr[2:0];
            2'd1:    w_wmask = 8'h03 << r_addr[2:0];
            2'd2:    w_wmask = 8'h0F << r_addr[2:0];
            default: w_wmask = 8'hFF;
        endcase
    end

    assign lsu_bus.mem_addr  = {r_addr[63:3], 3'b000};
    assign lsu_bus.mem_wen   = (r_op == OpStore);
    assign lsu_bus.mem_wdata = (r_op == OpStore) ? (r_wdata << {r_addr[2:0], 3'b000}) : 64'd0;
    assign lsu_bus.mem_wmask = (r_op == OpStore) ? w_wmask : 8'h00;

    assign w_rdata_sh = lsu_bus.mem_rdata >> {r_addr[2:0], 3'b000};
    assign w_sext     = ~r_funct3[2];

    always_comb begin
        w_load_data = w_rdata_sh;
        case (r_funct3[1:0])
            2'd0:    w_load_data = {{56{w_sext & w_rdata_sh[7]}}, w_rdata_sh[7:0]};
            2'd1:    w_load_data = {{48{w_sext & w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            2'd2:    w_load_data = {{32{w_sext & w_rdata_sh[31]}}, w_rdata_sh[31:0]};
            default: w_load_data = w_rdata_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op           <= OpPass;
            r_addr         <= 64'd0;
            r_wdata        <= 64'd0;
            r_funct3       <= 3'd0;
            r_rd           <= 5'd0;
            r_out_data     <= 64'd0;
            r_out_rd       <= 5'd0;
            r_out_misalign <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= w_op;
                r_addr   <= lsu_bus.in_addr;
                r_wdata  <= lsu_bus.in_wdata;
                r_funct3 <= lsu_bus.in_funct3;
                r_rd     <= lsu_bus.in_rd;
                // Pass-through and misaligned ops complete without touching memory.
                if (w_op == OpPass || w_misalign) begin
                    r_out_data     <= lsu_bus.in_addr;
                    r_out_rd       <= lsu_bus.in_rd;
                    r_out_misalign <= w_misalign;
                end
            end
            if (w_resp) begin
                r_out_data     <= (r_op == OpLoad) ? w_load_data : 64'd0;
                r_out_rd       <= r_rd;
                r_out_misalign <= 1'b0;
            end
        end
    end

    assign lsu_bus.out_data     = r_out_data;
    assign lsu_bus.out_rd       = r_out_rd;
    assign lsu_bus.out_misalign = r_out_misalign;
endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Bench for ysyx_220066_lsu: directed vector table, reset corner sequences and random ops
// checked against a byte-level reference model acting as both EX stage and data memory.
module tb_ysyx_220066_lsu;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [63:0] last_data;

    ysyx_220066_lsu_if bus ();

    ysyx_220066_lsu dut (
        .clk     (clk),
        .rst     (rst),
        .lsu_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        int          rdy;
        int          rsp;
        logic [63:0] rdata;
        logic [63:0] e_data;
        logic        e_mis;
        int          e_lat;
        logic [63:0] e_maddr;
        logic        e_wen;
        logic [7:0]  e_wmask;
        logic [63:0] e_wdata;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-granular view of the access, independent of any shift encoding.
    task automatic model(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int rdy, input int rsp,
                         output logic [63:0] e_data, output logic e_mis, output int e_lat,
                         output logic [63:0] e_maddr, output logic e_wen,
                         output logic [7:0] e_wmask, output logic [63:0] e_wdata);
        int          n;
        int          o;
        logic [63:0] v;
        bit          is_ld;
        bit          is_st;
        is_ld   = ren;
        is_st   = !ren && wen;
        n       = 1 << f3[1:0];
        o       = int'(addr % 64'd8);
        e_mis   = (is_ld || is_st) && ((addr % 64'(n)) != 64'd0);
        e_maddr = addr - (addr % 64'd8);
        e_wen   = is_st;
        e_wmask = 8'h00;
        e_wdata = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (is_st && b >= o && b < o + n) e_wmask[b] = 1'b1;
            if (is_st && b >= o) e_wdata[8*b +: 8] = wdata[8*(b-o) +: 8];
        end
        v = 64'd0;
        for (int i = 0; i < n && o + i < 8; i++) v[8*i +: 8] = rdata[8*(o+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) begin
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        if (e_mis || !(is_ld || is_st)) e_data = addr;
        else if (is_st) e_data = 64'd0;
        else e_data = v;
        e_lat = ((is_ld || is_st) && !e_mis) ? 3 + rdy + rsp : 1;
    endtask

    task automatic run_op(input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                          input int rdy, input int rsp, input logic [63:0] rdata,
                          input logic [63:0] e_data, input logic e_mis, input int e_lat,
                          input logic [63:0] e_maddr, input logic e_wen,
                          input logic [7:0] e_wmask, input logic [63:0] e_wdata);
        logic [63:0] f_addr;
        logic [63:0] f_wdata;
        logic [7:0]  f_mask;
        logic        f_wen;
        logic [63:0] o_data;
        logic [4:0]  o_rd;
        logic        o_mis;
        int          req_cyc = 0;
        int          lat = 0;
        int          rdy_w = 0;
        int          rsp_w = 0;
        bit          hs = 0;
        bit          stable = 1;
        bit          proto = 1;
        bit          held = 1;
        bit          got = 0;
        o_data = 'x;
        o_rd   = 'x;
        o_mis  = 1'bx;
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_ren    = ren;
        bus.in_wen    = wen;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        bus.in_rd     = rd;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_ren    = 1'($urandom);
        bus.in_wen    = 1'($urandom);
        bus.in_funct3 = 3'($urandom);
        bus.in_addr   = {$urandom, $urandom};
        bus.in_wdata  = {$urandom, $urandom};
        bus.in_rd     = 5'($urandom);
        for (int c = 1; c <= 60; c++) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = {$urandom, $urandom};
            if (bus.out_valid) begin
                lat    = c;
                got    = 1;
                o_data = bus.out_data;
                o_rd   = bus.out_rd;
                o_mis  = bus.out_misalign;
                break;
            end
            if (bus.in_ready) proto = 0;
            if (bus.out_data !== last_data) held = 0;
            if (bus.mem_req_valid) begin
                if (hs) proto = 0;
                if (req_cyc == 0) begin
                    f_addr  = bus.mem_addr;
                    f_wdata = bus.mem_wdata;
                    f_mask  = bus.mem_wmask;
                    f_wen   = bus.mem_wen;
                end else if (bus.mem_addr !== f_addr || bus.mem_wdata !== f_wdata ||
                             bus.mem_wmask !== f_mask || bus.mem_wen !== f_wen) begin
                    stable = 0;
                end
                req_cyc++;
                // Junk responses before/at the handshake must be ignored.
                bus.mem_resp_valid = 1'($urandom);
                if (rdy_w == rdy) begin
                    bus.mem_req_ready = 1'b1;
                    hs = 1;
                end else begin
                    rdy_w++;
                end
            end else if (hs) begin
                if (rsp_w == rsp) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = rdata;
                end else begin
                    rsp_w++;
                end
            end
            @(posedge clk); #1;
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        chk("out_valid_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(e_lat));
        chk("out_data", o_data, e_data);
        chk("out_rd", 64'(o_rd), 64'(rd));
        chk("out_misalign", 64'(o_mis), 64'(e_mis));
        chk("req_cycles", 64'(req_cyc), (e_lat > 1) ? 64'(rdy + 1) : 64'd0);
        chk("busy_protocol", 64'(proto), 64'd1);
        chk("out_held_busy", 64'(held), 64'd1);
        if (req_cyc > 0) begin
            chk("mem_addr", f_addr, e_maddr);
            chk("mem_wen", 64'(f_wen), 64'(e_wen));
            chk("mem_wmask", 64'(f_mask), 64'(e_wmask));
            if (e_wen) chk("mem_wdata", f_wdata, e_wdata);
            chk("req_stable", 64'(stable), 64'd1);
        end
        @(posedge clk); #1;
        chk("out_valid_pulse", 64'(bus.out_valid), 64'd0);
        chk("in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("out_data_held", bus.out_data, e_data);
        last_data = e_data;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'd0);
        chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_data"}, bus.out_data, 64'd0);
        chk({tag, "_out_rd"}, 64'(bus.out_rd), 64'd0);
        chk({tag, "_out_misalign"}, 64'(bus.out_misalign), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        last_data = 64'd0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_ren = 1'b0; bus.in_wen = 1'b0; bus.in_funct3 = 3'd0;
        bus.in_addr = 64'd0; bus.in_wdata = 64'd0; bus.in_rd = 5'd0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 64'd0;

        //        ren   wen   f3    addr                  wdata                 rd  rdy rsp rdata
        //        e_data                e_mis e_lat e_maddr            e_wen e_wmask e_wdata
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 64'h1234, 64'h0, 5'd5, 0, 0, 64'h0,
                    64'h1234, 1'b0, 1, 64'h0, 1'b0, 8'h00, 64'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 64'h8000_0003, 64'h0, 5'd1, 0, 0, 64'h0000_0000_8000_0000,
                    64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 64'h8000_0000, 1'b0, 8'h00, 64'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'd4, 64'h8000_0003, 64'h0, 5'd2, 0, 0, 64'h0000_0000_8000_0000,
                    64'h80, 1'b0, 3, 64'h8000_0000, 1'b0, 8'h00, 64'h0};
        tbl[3]  = '{1'b0, 1'b1, 3'd1, 64'h8000_0006, 64'hABCD, 5'd3, 0, 1, 64'h0,
                    64'h0, 1'b0, 4, 64'h8000_0000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd4, 4, 0, 64'h0,
                    64'h0, 1'b0, 7, 64'h8000_0008, 1'b1, 8'hFF, 64'h1122_3344_5566_7788};
        tbl[5]  = '{1'b1, 1'b0, 3'd2, 64'h8000_0002, 64'h0, 5'd6, 0, 0, 64'h0,
                    64'h8000_0002, 1'b1, 1, 64'h0, 1'b0, 8'h00, 64'h0};
        tbl[6]  = '{1'b1, 1'b0, 3'd7, 64'h8000_0010, 64'h0, 5'd7, 1, 2, 64'hDEAD_BEEF_CAFE_F00D,
                    64'hDEAD_BEEF_CAFE_F00D, 1'b0, 6, 64'h8000_0010, 1'b0, 8'h00, 64'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'd1, 64'h8000_0002, 64'h0, 5'd8, 0, 0, 64'h0000_0000_8001_0000,
                    64'hFFFF_FFFF_FFFF_8001, 1'b0, 3, 64'h8000_0000, 1'b0, 8'h00, 64'h0};
        tbl[8]  = '{1'b1, 1'b0, 3'd6, 64'h8000_0004, 64'h0, 5'd9, 0, 0, 64'hF234_5678_0000_0000,
                    64'h0000_0000_F234_5678, 1'b0, 3, 64'h8000_0000, 1'b0, 8'h00, 64'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 64'h8000_0007, 64'h1234_5678_9ABC_DEF0, 5'd10, 0, 0, 64'h0,
                    64'h0, 1'b0, 3, 64'h8000_0000, 1'b1, 8'h80, 64'hF000_0000_0000_0000};
        tbl[10] = '{1'b0, 1'b1, 3'd3, 64'h8000_000C, 64'h55, 5'd11, 0, 0, 64'h0,
                    64'h8000_000C, 1'b1, 1, 64'h0, 1'b0, 8'h00, 64'h0};
        tbl[11] = '{1'b1, 1'b1, 3'd2, 64'h8000_0000, 64'hFFFF, 5'd12, 0, 0, 64'h0000_0000_7FFF_FFFF,
                    64'h7FFF_FFFF, 1'b0, 3, 64'h8000_0000, 1'b0, 8'h00, 64'h0};
        tbl[12] = '{1'b1, 1'b0, 3'd5, 64'h8000_0001, 64'h0, 5'd13, 0, 0, 64'h0,
                    64'h8000_0001, 1'b1, 1, 64'h0, 1'b0, 8'h00, 64'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd2, 64'h8000_0004, 64'h0, 5'd14, 1, 3, 64'h8765_4321_0000_0000,
                    64'hFFFF_FFFF_8765_4321, 1'b0, 7, 64'h8000_0000, 1'b0, 8'h00, 64'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk_reset_outputs("rst");
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].ren, tbl[i].wen, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rd,
                   tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].e_data, tbl[i].e_mis,
                   tbl[i].e_lat, tbl[i].e_maddr, tbl[i].e_wen, tbl[i].e_wmask, tbl[i].e_wdata);
        end

        // Reset while waiting for the response; a stale response afterwards must be dropped.
        bus.in_valid = 1'b1; bus.in_ren = 1'b1; bus.in_wen = 1'b0; bus.in_funct3 = 3'd3;
        bus.in_addr = 64'h8000_0020; bus.in_rd = 5'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rw_req_valid", 64'(bus.mem_req_valid), 64'd1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        chk("rw_in_wait", 64'(bus.mem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("rw_in_ready_in_reset", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rw_in_ready", 64'(bus.in_ready), 64'd1);
        chk_reset_outputs("rw");
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        chk("rw_stale_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rw_stale_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rw_stale_out_data", bus.out_data, 64'd0);
        @(posedge clk); #1;
        chk("rw_stale_out_valid2", 64'(bus.out_valid), 64'd0);

        // Reset while the request is back-pressured drops mem_req_valid immediately.
        bus.in_valid = 1'b1; bus.in_ren = 1'b0; bus.in_wen = 1'b1; bus.in_funct3 = 3'd3;
        bus.in_addr = 64'h8000_0040; bus.in_wdata = 64'h1; bus.in_rd = 5'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rq_req_valid", 64'(bus.mem_req_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rq_req_dropped", 64'(bus.mem_req_valid), 64'd0);
        chk("rq_in_ready", 64'(bus.in_ready), 64'd1);
        last_data = 64'd0;

        for (int k = 0; k < 150; k++) begin
            logic        ren, wen, e_mis, e_wen;
            logic [2:0]  f3;
            logic [4:0]  rd;
            logic [7:0]  e_wmask;
            logic [63:0] addr, wdata, rdata, e_data, e_maddr, e_wdata;
            int          rdy, rsp, e_lat;
            ren   = 1'($urandom);
            wen   = 1'($urandom);
            f3    = 3'($urandom);
            rd    = 5'($urandom);
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rdy   = int'($urandom_range(0, 3));
            rsp   = int'($urandom_range(0, 3));
            model(ren, wen, f3, addr, wdata, rdata, rdy, rsp,
                  e_data, e_mis, e_lat, e_maddr, e_wen, e_wmask, e_wdata);
            run_op(ren, wen, f3, addr, wdata, rd, rdy, rsp, rdata,
                   e_data, e_mis, e_lat, e_maddr, e_wen, e_wmask, e_wdata);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
